// File: rtl/iq_occupancy_tracker_pkg.sv
// Shared types and helpers for the issue-queue occupancy tracker.
// Default geometry matches the reference slot group (16 entries, 4-in, 2-out).
package iq_pkg;

  localparam int DEF_CAPACITY     = 16;
  localparam int DEF_MAX_IN       = 4;
  localparam int DEF_MAX_OUT      = 2;
  localparam int DEF_FLUSH_CYCLES = 2;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } iq_state_e;

  function automatic int min_u(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/iq_occupancy_tracker_credit_calc.sv
// Pure combinational credit math: kill survivors, send offer/grant, accept room and next count.
// Everything is evaluated one bit wider than the count so no intermediate can wrap.
module iq_credit_calc
  import iq_pkg::*;
#(
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int MAX_IN   = DEF_MAX_IN,
  parameter int MAX_OUT  = DEF_MAX_OUT,
  parameter int CW       = $clog2(CAPACITY + 1),
  parameter int IW       = $clog2(MAX_IN + 1),
  parameter int OW       = $clog2(MAX_OUT + 1)
) (
  input  logic [CW-1:0] count_i,
  input  logic          kill_all_i,
  input  logic [CW-1:0] kill_i,
  input  logic          lock_accept_i,
  input  logic          lock_send_i,
  input  logic          flushing_i,
  input  logic [OW-1:0] next_accepting_i,
  input  logic [IW-1:0] prev_sending_i,
  output logic [CW-1:0] living_o,
  output logic [OW-1:0] want_send_o,
  output logic [IW-1:0] can_accept_o,
  output logic [OW-1:0] sending_o,
  output logic [IW-1:0] accepting_o,
  output logic [CW-1:0] after_sending_o,
  output logic [CW-1:0] after_receiving_o
);

  localparam int WX = CW + 1;

  logic [WX-1:0] cnt_x, kill_x, live_x, want_x, send_x, aft_s_x;
  logic [WX-1:0] can_x, room_x, acc_x, take_x, aft_r_x;

  always_comb begin
    cnt_x  = WX'(count_i);
    kill_x = WX'(kill_i);

    // Kill removes the youngest entries first; over-kill saturates at empty.
    live_x = '0;
    if (!kill_all_i && (kill_x <= cnt_x))
      live_x = cnt_x - kill_x;

    want_x = '0;
    if (!(lock_send_i || flushing_i))
      want_x = WX'(min_u(MAX_OUT, int'(live_x)));
    send_x  = WX'(min_u(int'(next_accepting_i), int'(want_x)));
    aft_s_x = live_x - send_x;

    can_x = '0;
    if (!(lock_accept_i || flushing_i || kill_all_i))
      can_x = WX'(min_u(MAX_IN, CAPACITY));
    room_x = WX'(CAPACITY) - aft_s_x;
    acc_x  = WX'(min_u(int'(can_x), int'(room_x)));

    // Deliveries beyond the granted credit are dropped, never counted.
    take_x  = WX'(min_u(int'(prev_sending_i), int'(acc_x)));
    aft_r_x = aft_s_x + take_x;
  end

  assign living_o          = CW'(live_x);
  assign want_send_o       = OW'(want_x);
  assign can_accept_o      = IW'(can_x);
  assign sending_o         = OW'(send_x);
  assign accepting_o       = IW'(acc_x);
  assign after_sending_o   = CW'(aft_s_x);
  assign after_receiving_o = CW'(aft_r_x);

endmodule

// File: rtl/iq_occupancy_tracker.sv
// Registered occupancy for one issue-queue slot group: count, flush FSM and sticky error.
// Credits are computed combinationally from the current count and neighbour handshakes.
module iq_occupancy_tracker
  import iq_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int MAX_IN       = DEF_MAX_IN,
  parameter int MAX_OUT      = DEF_MAX_OUT,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int CW           = $clog2(CAPACITY + 1),
  parameter int IW           = $clog2(MAX_IN + 1),
  parameter int OW           = $clog2(MAX_OUT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          kill_all_i,
  input  logic [CW-1:0] kill_i,
  input  logic          lock_accept_i,
  input  logic          lock_send_i,
  input  logic [OW-1:0] next_accepting_i,
  input  logic [IW-1:0] prev_sending_i,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] living_o,
  output logic [OW-1:0] want_send_o,
  output logic [IW-1:0] can_accept_o,
  output logic [OW-1:0] sending_o,
  output logic [IW-1:0] accepting_o,
  output logic [CW-1:0] after_sending_o,
  output logic [CW-1:0] after_receiving_o,
  output logic          flushing_o,
  output logic          err_o
);

  localparam int            FW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

  iq_state_e     state_q;
  logic [FW-1:0] flush_cnt_q;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          flushing;

  assign flushing = (state_q == FLUSH);

  iq_credit_calc #(
    .CAPACITY(CAPACITY),
    .MAX_IN  (MAX_IN),
    .MAX_OUT (MAX_OUT),
    .CW      (CW),
    .IW      (IW),
    .OW      (OW)
  ) u_credit (
    .count_i          (count_q),
    .kill_all_i       (kill_all_i),
    .kill_i           (kill_i),
    .lock_accept_i    (lock_accept_i),
    .lock_send_i      (lock_send_i),
    .flushing_i       (flushing),
    .next_accepting_i (next_accepting_i),
    .prev_sending_i   (prev_sending_i),
    .living_o         (living_o),
    .want_send_o      (want_send_o),
    .can_accept_o     (can_accept_o),
    .sending_o        (sending_o),
    .accepting_o      (accepting_o),
    .after_sending_o  (after_sending_o),
    .after_receiving_o(after_receiving_o)
  );

  assign count_d = after_receiving_o;

  // Protocol violations latch until reset so a single bad cycle is never missed.
  always_comb begin
    err_d = err_q;
    if (prev_sending_i > accepting_o)              err_d = 1'b1;
    if (!kill_all_i && (kill_i > count_q))         err_d = 1'b1;
    if (int'(next_accepting_i) > MAX_OUT)          err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q     <= '0;
      err_q       <= 1'b0;
      state_q     <= RUN;
      flush_cnt_q <= '0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      case (state_q)
        RUN: begin
          if (kill_all_i) begin
            state_q     <= FLUSH;
            flush_cnt_q <= FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (kill_all_i)
            flush_cnt_q <= FLUSH_LOAD;
          else if (flush_cnt_q == '0)
            state_q <= RUN;
          else
            flush_cnt_q <= flush_cnt_q - 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign count_o    = count_q;
  assign flushing_o = flushing;
  assign err_o      = err_q;

endmodule

// File: tb/tb_iq_occupancy_tracker.sv
// Directed bench for iq_occupancy_tracker at CAPACITY=16, MAX_IN=4, MAX_OUT=2, FLUSH_CYCLES=2.
module tb_iq_occupancy_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kill_all;
  logic [4:0] kill;
  logic       lock_accept, lock_send;
  logic [1:0] next_accepting;
  logic [2:0] prev_sending;
  logic [4:0] count, living, after_sending, after_receiving;
  logic [1:0] want_send, sending;
  logic [2:0] can_accept, accepting;
  logic       flushing, err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iq_occupancy_tracker #(
    .CAPACITY(16), .MAX_IN(4), .MAX_OUT(2), .FLUSH_CYCLES(2)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .kill_all_i       (kill_all),
    .kill_i           (kill),
    .lock_accept_i    (lock_accept),
    .lock_send_i      (lock_send),
    .next_accepting_i (next_accepting),
    .prev_sending_i   (prev_sending),
    .count_o          (count),
    .living_o         (living),
    .want_send_o      (want_send),
    .can_accept_o     (can_accept),
    .sending_o        (sending),
    .accepting_o      (accepting),
    .after_sending_o  (after_sending),
    .after_receiving_o(after_receiving),
    .flushing_o       (flushing),
    .err_o            (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ps, input int na, input int k, input logic ka);
    prev_sending   = 3'(ps);
    next_accepting = 2'(na);
    kill           = 5'(k);
    kill_all       = ka;
  endtask

  // Async pulse between edges; state must clear before any clock edge arrives.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_count"},    32'(count),    0);
    chk({tag, "_err"},      32'(err),      0);
    chk({tag, "_flushing"}, 32'(flushing), 0);
    rst_n = 1'b1;
    cyc();
  endtask

  int fill_cnt[5] = '{4, 8, 12, 16, 16};
  int fill_acc[5] = '{4, 4, 4, 4, 0};
  int drn_send[3] = '{2, 1, 0};
  int drn_cnt[3]  = '{1, 0, 0};

  initial begin
    rst_n = 1'b0;
    lock_accept = 1'b0;
    lock_send   = 1'b0;
    drive(0, 0, 0, 1'b0);
    #12;
    chk("rst_count",     32'(count),           0);
    chk("rst_living",    32'(living),          0);
    chk("rst_want_send", 32'(want_send),       0);
    chk("rst_sending",   32'(sending),         0);
    chk("rst_after_rcv", 32'(after_receiving), 0);
    chk("rst_flushing",  32'(flushing),        0);
    chk("rst_err",       32'(err),             0);
    rst_n = 1'b1;
    cyc();

    // Fill: 4 per cycle until full, last delivery exceeds credit
    drive(4, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1 chk("fill_accepting", 32'(accepting), 32'(fill_acc[i]));
      cyc();
      chk("fill_count", 32'(count), 32'(fill_cnt[i]));
    end
    chk("fill_err", 32'(err), 1);
    drive(0, 0, 0, 1'b0);
    pulse_reset("rst_full");

    // Drain from 3 at two per cycle
    drive(3, 0, 0, 1'b0);
    cyc();
    chk("drain_start", 32'(count), 3);
    drive(0, 2, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("drain_sending", 32'(sending), 32'(drn_send[i]));
      cyc();
      chk("drain_count", 32'(count), 32'(drn_cnt[i]));
    end
    chk("drain_want_empty", 32'(want_send), 0);

    // Partial kill with simultaneous send and receive
    drive(4, 0, 0, 1'b0); cyc();
    cyc();
    drive(2, 0, 0, 1'b0); cyc();
    chk("kill_start", 32'(count), 10);
    drive(4, 2, 3, 1'b0);
    #1;
    chk("kill_living",    32'(living),          7);
    chk("kill_sending",   32'(sending),         2);
    chk("kill_after_snd", 32'(after_sending),   5);
    chk("kill_accepting", 32'(accepting),       4);
    chk("kill_after_rcv", 32'(after_receiving), 9);
    cyc();
    chk("kill_count", 32'(count), 9);
    chk("kill_err",   32'(err),   0);

    // Flush: kill_all overrides send and accept, then two blocked cycles
    drive(0, 2, 0, 1'b1);
    #1;
    chk("ka_living",    32'(living),          0);
    chk("ka_sending",   32'(sending),         0);
    chk("ka_accepting", 32'(accepting),       0);
    chk("ka_after_rcv", 32'(after_receiving), 0);
    cyc();
    drive(0, 0, 0, 1'b0);
    chk("fl1_count",     32'(count),     0);
    chk("fl1_flushing",  32'(flushing),  1);
    chk("fl1_accepting", 32'(accepting), 0);
    cyc();
    chk("fl2_flushing",  32'(flushing),  1);
    chk("fl2_accepting", 32'(accepting), 0);
    cyc();
    chk("fl3_flushing",  32'(flushing),  0);
    chk("fl3_accepting", 32'(accepting), 4);
    chk("fl3_err",       32'(err),       0);

    // Over-delivery against limited room: only the granted 2 are counted
    drive(4, 0, 0, 1'b0); cyc(); cyc(); cyc();
    drive(2, 0, 0, 1'b0); cyc();
    chk("ovr_start", 32'(count), 14);
    drive(4, 0, 0, 1'b0);
    #1 chk("ovr_accepting", 32'(accepting), 2);
    cyc();
    chk("ovr_count", 32'(count), 16);
    chk("ovr_err",   32'(err),   1);
    drive(0, 0, 0, 1'b0);
    cyc();
    chk("ovr_err_held", 32'(err),   1);
    chk("ovr_count_hd", 32'(count), 16);
    drive(0, 0, 8, 1'b0);
    cyc();
    chk("k8_count", 32'(count), 8);
    drive(0, 0, 0, 1'b0);
    pulse_reset("rst_mid");

    // Over-kill saturates at zero and flags
    drive(3, 0, 0, 1'b0); cyc();
    chk("ok_start", 32'(count), 3);
    chk("ok_err0",  32'(err),   0);
    drive(0, 0, 5, 1'b0);
    #1 chk("ok_living", 32'(living), 0);
    cyc();
    chk("ok_count", 32'(count), 0);
    chk("ok_err",   32'(err),   1);
    drive(0, 0, 0, 1'b0);
    pulse_reset("rst_ok");

    // next_accepting above MAX_OUT flags
    drive(0, 3, 0, 1'b0); cyc();
    chk("na_err", 32'(err), 1);
    drive(0, 0, 0, 1'b0);
    pulse_reset("rst_na");

    // Locks
    drive(4, 0, 0, 1'b0); cyc();
    lock_accept = 1'b1;
    lock_send   = 1'b1;
    drive(0, 2, 0, 1'b0);
    #1;
    chk("lk_can_accept", 32'(can_accept), 0);
    chk("lk_accepting",  32'(accepting),  0);
    chk("lk_want_send",  32'(want_send),  0);
    chk("lk_sending",    32'(sending),    0);
    cyc();
    chk("lk_count", 32'(count), 4);
    lock_send = 1'b0;
    #1 chk("ls_sending", 32'(sending), 2);
    cyc();
    chk("ls_count", 32'(count), 2);
    lock_accept = 1'b0;
    drive(0, 0, 0, 1'b0);

    // Async reset while flushing
    drive(0, 0, 0, 1'b1); cyc();
    drive(0, 0, 0, 1'b0);
    chk("rf_flushing", 32'(flushing), 1);
    pulse_reset("rst_flush");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
